// File: rtl/la_pkg.sv
// Shared types and sizing helpers for the logic-analyser capture path.
package la_pkg;

  localparam int LA_ADDR_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } cap_state_t;

  function automatic int la_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/wrap_cnt.sv
// Free-wrapping W-bit counter with synchronous clear (priority) and count enable.
module wrap_cnt #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: fills the circular sample RAM, arms the trigger once the
// pre-trigger window is stored, then counts post-trigger samples to completion.
module capture_ctrl
  import la_pkg::*;
#(
  parameter int ADDR_W = LA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              abort,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              smpl_en,
  input  logic              triggered,
  input  logic              clr_done,
  output logic              armed,
  output logic              set_capture_done,
  output logic              capture_done,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] end_addr,
  output logic              busy
);

  localparam int              DEPTH   = la_depth(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  cap_state_t        state_q, state_d;
  logic              armed_q, armed_d;
  logic              scd_q, scd_d;
  logic              cdone_q, cdone_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] trig_pos_q, trig_pos_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;

  logic [ADDR_W-1:0] wptr, pre_cnt, post_cnt;
  logic [ADDR_W:0]   pre_inc, post_inc;
  logic              start, trig_acc, pre_hit, post_hit;

  assign start    = run & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign trig_acc = (state_q == ST_ARMED) & triggered & ~abort;
  assign we       = smpl_en & busy_q;

  wrap_cnt #(.W(ADDR_W)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (we),
    .cnt   (wptr)
  );

  wrap_cnt #(.W(ADDR_W)) u_pre_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (we & (state_q == ST_PRE)),
    .cnt   (pre_cnt)
  );

  // The write that coincides with the trigger edge belongs to the pre-trigger window.
  wrap_cnt #(.W(ADDR_W)) u_post_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (trig_acc),
    .en    (we & (state_q == ST_POST)),
    .cnt   (post_cnt)
  );

  // Hit tests look at the count the current write is about to produce.
  assign pre_inc  = {1'b0, pre_cnt} + (ADDR_W+1)'(1);
  assign post_inc = {1'b0, post_cnt} + (ADDR_W+1)'(1);
  assign pre_hit  = pre_inc == (DEPTH_V - {1'b0, trig_pos_q});
  assign post_hit = post_inc == {1'b0, trig_pos_q};

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    scd_d      = 1'b0;
    cdone_d    = cdone_q;
    trig_pos_d = trig_pos_q;
    end_addr_d = end_addr_q;
    if (clr_done)
      cdone_d = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (run) begin
          state_d    = ST_PRE;
          armed_d    = 1'b0;
          cdone_d    = 1'b0;
          trig_pos_d = (trig_pos == '0) ? ADDR_W'(1) : trig_pos;
        end
      end
      ST_PRE: begin
        if (abort) begin
          state_d = ST_IDLE;
          armed_d = 1'b0;
        end else if (we && pre_hit) begin
          state_d = ST_ARMED;
          armed_d = 1'b1;
        end
      end
      ST_ARMED: begin
        if (abort) begin
          state_d = ST_IDLE;
          armed_d = 1'b0;
        end else if (triggered) begin
          state_d = ST_POST;
          armed_d = 1'b0;
        end
      end
      ST_POST: begin
        if (abort) begin
          state_d = ST_IDLE;
          armed_d = 1'b0;
        end else if (we && post_hit) begin
          state_d    = ST_DONE;
          scd_d      = 1'b1;
          cdone_d    = 1'b1;
          end_addr_d = wptr;
        end
      end
      default: begin
        state_d = ST_IDLE;
        armed_d = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_PRE) | (state_d == ST_ARMED) | (state_d == ST_POST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      scd_q      <= 1'b0;
      cdone_q    <= 1'b0;
      busy_q     <= 1'b0;
      trig_pos_q <= '0;
      end_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      scd_q      <= scd_d;
      cdone_q    <= cdone_d;
      busy_q     <= busy_d;
      trig_pos_q <= trig_pos_d;
      end_addr_q <= end_addr_d;
    end
  end

  assign armed            = armed_q;
  assign set_capture_done = scd_q;
  assign capture_done     = cdone_q;
  assign busy             = busy_q;
  assign waddr            = wptr;
  assign end_addr         = end_addr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl at ADDR_W=4: directed scenarios plus random traffic,
// each cycle compared against a sample-counting reference model.
module tb_capture_ctrl;

  localparam int AW = 4;
  localparam int D  = 16;
  localparam int PH_IDLE = 0, PH_PRE = 1, PH_ARMED = 2, PH_POST = 3, PH_DONE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          run = 1'b0, abort = 1'b0, smpl_en = 1'b0, triggered = 1'b0, clr_done = 1'b0;
  logic [AW-1:0] trig_pos = '0;
  logic          armed, set_capture_done, capture_done, we, busy;
  logic [AW-1:0] waddr, end_addr;

  int total = 0;
  int bad   = 0;

  int m_ph, m_wptr, m_npre, m_npost, m_tpq, m_end;
  bit m_armed, m_scd, m_cdone;

  capture_ctrl #(.ADDR_W(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .run              (run),
    .abort            (abort),
    .trig_pos         (trig_pos),
    .smpl_en          (smpl_en),
    .triggered        (triggered),
    .clr_done         (clr_done),
    .armed            (armed),
    .set_capture_done (set_capture_done),
    .capture_done     (capture_done),
    .we               (we),
    .waddr            (waddr),
    .end_addr         (end_addr),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy();
    return (m_ph == PH_PRE) || (m_ph == PH_ARMED) || (m_ph == PH_POST);
  endfunction

  task automatic model_reset();
    m_ph = PH_IDLE; m_wptr = 0; m_npre = 0; m_npost = 0; m_tpq = 0; m_end = 0;
    m_armed = 0; m_scd = 0; m_cdone = 0;
  endtask

  task automatic model_step(input bit r, a, input int tp, input bit tr, cd, ew);
    int old_w;
    old_w  = m_wptr;
    m_scd  = 0;
    if (ew) m_wptr = (m_wptr + 1) % D;
    case (m_ph)
      PH_IDLE, PH_DONE: begin
        if (r) begin
          m_ph = PH_PRE; m_wptr = 0; m_npre = 0; m_cdone = 0;
          m_tpq = (tp == 0) ? 1 : tp;
        end else if (cd) m_cdone = 0;
      end
      PH_PRE: begin
        if (a) m_ph = PH_IDLE;
        else if (ew) begin
          m_npre++;
          if (m_npre == D - m_tpq) begin m_ph = PH_ARMED; m_armed = 1; end
        end
      end
      PH_ARMED: begin
        if (a) begin m_ph = PH_IDLE; m_armed = 0; end
        else if (tr) begin m_ph = PH_POST; m_armed = 0; m_npost = 0; end
      end
      PH_POST: begin
        if (a) m_ph = PH_IDLE;
        else if (ew) begin
          m_npost++;
          if (m_npost == m_tpq) begin
            m_ph = PH_DONE; m_scd = 1; m_cdone = 1; m_end = old_w;
          end
        end
      end
      default: m_ph = PH_IDLE;
    endcase
  endtask

  // One clock: drive at edge+1, check the write port before the edge, registers after it.
  task automatic cyc(input bit r, a, input int tp, input bit se, tr_req, cd);
    bit tr, ew;
    tr = tr_req && ((m_ph == PH_ARMED) || (m_ph == PH_POST));
    run = r; abort = a; trig_pos = AW'(tp); smpl_en = se; triggered = tr; clr_done = cd;
    #1;
    ew = se && m_busy();
    chk("we", we, ew);
    chk("waddr", waddr, m_wptr);
    if (triggered) chk("trig_legal", busy, 1);
    @(posedge clk);
    model_step(r, a, tp, tr, cd, ew);
    #1;
    chk("armed", armed, m_armed);
    chk("set_capture_done", set_capture_done, m_scd);
    chk("capture_done", capture_done, m_cdone);
    chk("busy", busy, m_busy());
    chk("end_addr", end_addr, m_end);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 0; abort = 0; smpl_en = 0; triggered = 0; clr_done = 0; trig_pos = '0;
    #1;
    chk("rst_armed", armed, 0);
    chk("rst_scd", set_capture_done, 0);
    chk("rst_cdone", capture_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_end_addr", end_addr, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_to_done(input int tp, input int limit);
    for (int i = 0; i < limit && m_ph != PH_DONE; i++) cyc(0, 0, tp, 1, 1, 0);
    chk("reached_done", capture_done, 1);
  endtask

  initial begin
    int scd_seen;
    #2;
    do_reset();

    // Fill the pre-trigger window with trig_pos=4, then trigger on write 20.
    cyc(1, 0, 4, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 0, 4, 1, (i == 20), 0);
      if (i == 11) chk("armed_before_12", armed, 0);
      if (i == 12) chk("armed_after_12", armed, 1);
      if (i == 17) chk("armed_after_wrap", armed, 1);
    end
    for (int i = 0; i < 10 && m_ph != PH_DONE; i++) cyc(0, 0, 4, 1, 1, 0);
    chk("t3_end_addr", end_addr, 7);
    chk("t3_cdone", capture_done, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4, 1, 0, 0);

    // Reset in the middle of a capture.
    cyc(1, 0, 6, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 6, 1, 0, 0);
    do_reset();

    // trig_pos=0 behaves as 1, samples every third cycle.
    scd_seen = 0;
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 150 && m_ph != PH_DONE; i++) begin
      cyc(0, 0, 0, (i % 3 == 2), 1, 0);
      if (set_capture_done) scd_seen++;
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 0, 0);
      if (set_capture_done) scd_seen++;
    end
    chk("t4_pulses", scd_seen, 1);
    chk("t4_end_addr", end_addr, 15);

    // Abort while armed, run ignored while busy, restart from DONE.
    cyc(1, 0, 4, 0, 0, 0);
    for (int i = 0; i < 14; i++) cyc(0, 0, 4, 1, 0, 0);
    cyc(0, 1, 4, 1, 0, 0);
    chk("t5_abort_busy", busy, 0);
    cyc(1, 0, 3, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 3, 1, 0, 0);
    cyc(1, 0, 9, 1, 0, 0);
    run_to_done(3, 40);
    cyc(1, 0, 5, 0, 0, 0);
    chk("t5_restart_cdone", capture_done, 0);
    run_to_done(5, 40);

    // clr_done and run together from DONE: run wins.
    cyc(1, 0, 2, 0, 0, 1);
    chk("t6_busy", busy, 1);
    chk("t6_cdone", capture_done, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 60) == 0), $urandom_range(0, 15),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
